uart_bus_bridge: RTL
====================

Name: uart_bus_bridge

Overview:
- Serial-to-bus initiator: receives 8N1 command frames on `rx`, drives the SoC peripheral bus as master, and returns read data on `tx`.
- It is the other end of the peripheral bus that memory-mapped slaves such as the uart block respond on.
- Used for debug and boot: it lets a host PC poke and peek any 8-bit I/O address without CPU involvement.

Parameters:
- PRESCALE, 103: sample tick asserted every PRESCALE+1 clocks; 16 ticks per bit, so one bit time = 16*(PRESCALE+1) clocks.
- CMD_WRITE, 8'h57: command byte ('W') that starts a write.
- CMD_READ, 8'h52: command byte ('R') that starts a read.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- rx  input  1  serial in, idle high, asynchronous to clk.
- tx  output  1  serial out, idle high.
- address  output  8  bus address.
- dout  output  8  bus write data.
- w_en  output  1  bus write strobe, one clock per access.
- r_en  output  1  bus read strobe, one clock per access.
- din  input  8  bus read data; registered by the slave, valid the clock after r_en.
- busy  output  1  high whenever the command FSM is not in S_CMD or the transmitter is active.
- frame_err  output  1  one-clock pulse when a received stop bit is 0.

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - tx=1, address=0, dout=0, w_en=0, r_en=0, busy=0, frame_err=0.
  - Prescaler, receiver, transmitter and command FSM return to idle; any partial byte or command is discarded.
- Prescaler: counts 0..PRESCALE; tick is high for one clock when the count wraps. It is free-running after reset.
- Input synchroniser: `rx` passes through 2 flops on every clk (not gated by tick).
- Receiver, 16x oversampled, advancing on ticks only:
  - RX_IDLE: wait for synchronised rx=0.
  - RX_START: after 8 ticks, re-sample. If rx=1 it was a glitch: return to RX_IDLE. Else go to RX_DATA.
  - RX_DATA: sample every 16 ticks, 8 bits, LSB first.
  - RX_STOP: sample after 16 more ticks.
    - If stop=1: pulse rx_valid for one clock with the byte.
    - If stop=0: pulse frame_err and go to RX_BREAK.
  - RX_BREAK: wait for rx=1, then go to RX_IDLE.
- Transmitter:
  - Loads a byte when tx_start is high and it is idle.
  - Sends start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts 16 ticks.
  - tx_busy is high from load until the end of the stop bit.
  - tx first drops on the first tick after load.
- Command FSM (advances on rx_valid, not on ticks):
  - S_CMD:
    - CMD_WRITE -> S_WADDR.
    - CMD_READ -> S_RADDR.
    - Any other byte is ignored; stay in S_CMD.
  - S_WADDR: latch address -> S_WDATA.
  - S_WDATA: latch dout -> S_WRITE.
  - S_WRITE: w_en=1 for exactly one clock with address and dout stable -> S_CMD.
  - S_RADDR: latch address -> S_READ.
  - S_READ: r_en=1 for one clock -> S_RCAP.
  - S_RCAP: capture din on the clock after r_en -> S_TXWAIT.
  - S_TXWAIT: once tx_busy=0, assert tx_start for one clock -> S_CMD.
- Boundary rules:
  - Frame error at any point: abort the command and return to S_CMD. No bus access occurs for a partial command.
  - rx_valid arriving while the FSM is in S_WRITE, S_READ, S_RCAP or S_TXWAIT: the byte is dropped.
  - address and dout hold their last values between accesses.
  - w_en and r_en are never high simultaneously.
  - A command may begin while the previous response byte is still transmitting; its response waits in S_TXWAIT.

Optional Feature:
- Macro: UART_BRIDGE_ACK_EN.
- Defined: after S_WRITE, the FSM goes to S_TXWAIT with response byte 8'h06, so every write is acknowledged over tx.
- Undefined: writes produce no serial output and tx stays idle. Read behaviour is the same either way.

Test Plan (PRESCALE=3, so bit time = 64 clocks):
- Write: send 0x57,0x10,0xA5 -> exactly one clock with w_en=1, address=0x10, dout=0xA5; no r_en pulse; tx stays 1 (ACK macro off).
- Read: send 0x52,0x11, slave model returns 0x3C the clock after r_en -> r_en pulses once with address=0x11; tx then emits frame 0,00111100 LSB-first,1 (0x3C).
- Framing: send 0x57 with stop bit 0 -> frame_err pulses once; FSM in S_CMD; a following valid 'W' command executes normally.
- Noise: send unknown byte 0x00, then a 20-clock low glitch on rx -> no bus strobes, no frame_err, busy=0.
- Reset: assert rst mid-way through the address byte of a write -> all outputs at reset values next clock; a fresh full command then works.
- ACK: with UART_BRIDGE_ACK_EN defined, write command -> w_en pulse followed by transmitted byte 0x06; a read issued back-to-back waits for the ACK to finish before its data byte is sent.

Source files
------------

// File: rtl/uart_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_bus_bridge
// Description : 8N1 serial command receiver that masters the peripheral bus
//               ('W' addr data / 'R' addr) and returns read data on tx.
//               Optional macro UART_BRIDGE_ACK_EN acknowledges writes (0x06).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_bridge #(
    parameter int          PRESCALE  = 103,
    parameter logic [7:0]  CMD_WRITE = 8'h57,
    parameter logic [7:0]  CMD_READ  = 8'h52
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] address,
    output logic [7:0] dout,
    output logic       w_en,
    output logic       r_en,
    input  logic [7:0] din,
    output logic       busy,
    output logic       frame_err
);

    localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
    } rx_state_e;

    typedef enum logic [2:0] {
        S_CMD, S_WADDR, S_WDATA, S_WRITE, S_RADDR, S_READ, S_RCAP, S_TXWAIT
    } cmd_state_e;

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;
    logic          rx_meta_q, rx_sync_q;
    rx_state_e     rx_state_q, rx_state_d;
    logic [3:0]    rx_tcnt_q, rx_tcnt_d;
    logic [2:0]    rx_bcnt_q, rx_bcnt_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_valid;
    logic          tx_q, tx_d;
    logic          tx_active_q, tx_active_d;
    logic [3:0]    tx_tcnt_q, tx_tcnt_d;
    logic [3:0]    tx_bcnt_q, tx_bcnt_d;
    logic [9:0]    tx_frame_q, tx_frame_d;
    logic          tx_start;
    cmd_state_e    cmd_q, cmd_d;
    logic [7:0]    address_q, address_d;
    logic [7:0]    dout_q, dout_d;
    logic [7:0]    resp_q, resp_d;

    assign tick      = (pre_q == PW'(PRESCALE));
    assign pre_d     = tick ? '0 : pre_q + 1'b1;
    assign tx        = tx_q;
    assign address   = address_q;
    assign dout      = dout_q;
    assign busy      = (cmd_q != S_CMD) || tx_active_q;

    // Receiver: start is confirmed mid-bit, then every 16 ticks lands mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bcnt_d  = rx_bcnt_q;
        rx_shift_d = rx_shift_q;
        rx_valid   = 1'b0;
        frame_err  = 1'b0;
        if (tick) begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync_q) begin
                        rx_state_d = RX_START;
                        rx_tcnt_d  = 4'd0;
                    end
                end
                RX_START: begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd7) begin
                        rx_tcnt_d  = 4'd0;
                        rx_bcnt_d  = 3'd0;
                        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                        rx_bcnt_d  = rx_bcnt_q + 3'd1;
                        if (rx_bcnt_q == 3'd7) rx_state_d = RX_STOP;
                    end
                end
                RX_STOP: begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        if (rx_sync_q) begin
                            rx_valid   = 1'b1;
                            rx_state_d = RX_IDLE;
                        end else begin
                            frame_err  = 1'b1;
                            rx_state_d = RX_BREAK;
                        end
                    end
                end
                RX_BREAK: if (rx_sync_q) rx_state_d = RX_IDLE;
                default:  rx_state_d = RX_IDLE;
            endcase
        end
    end

    // Transmitter: the frame shifts out LSB first, one bit per 16 ticks.
    always_comb begin
        tx_d        = tx_q;
        tx_active_d = tx_active_q;
        tx_tcnt_d   = tx_tcnt_q;
        tx_bcnt_d   = tx_bcnt_q;
        tx_frame_d  = tx_frame_q;
        if (!tx_active_q) begin
            if (tx_start) begin
                tx_frame_d  = {1'b1, resp_q, 1'b0};
                tx_active_d = 1'b1;
                tx_tcnt_d   = 4'd0;
                tx_bcnt_d   = 4'd0;
            end
        end else if (tick) begin
            if (tx_tcnt_q == 4'd0) begin
                tx_d       = tx_frame_q[0];
                tx_frame_d = {1'b1, tx_frame_q[9:1]};
            end
            tx_tcnt_d = tx_tcnt_q + 4'd1;
            if (tx_tcnt_q == 4'd15) begin
                tx_bcnt_d = tx_bcnt_q + 4'd1;
                if (tx_bcnt_q == 4'd9) tx_active_d = 1'b0;
            end
        end
    end

    always_comb begin
        cmd_d     = cmd_q;
        address_d = address_q;
        dout_d    = dout_q;
        resp_d    = resp_q;
        w_en      = 1'b0;
        r_en      = 1'b0;
        tx_start  = 1'b0;
        case (cmd_q)
            S_CMD: begin
                if (rx_valid) begin
                    if (rx_shift_q == CMD_WRITE)     cmd_d = S_WADDR;
                    else if (rx_shift_q == CMD_READ) cmd_d = S_RADDR;
                end
            end
            S_WADDR: begin
                if (frame_err) cmd_d = S_CMD;
                else if (rx_valid) begin
                    address_d = rx_shift_q;
                    cmd_d     = S_WDATA;
                end
            end
            S_WDATA: begin
                if (frame_err) cmd_d = S_CMD;
                else if (rx_valid) begin
                    dout_d = rx_shift_q;
                    cmd_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                w_en = 1'b1;
`ifdef UART_BRIDGE_ACK_EN
                resp_d = 8'h06;
                cmd_d  = S_TXWAIT;
`else
                cmd_d  = S_CMD;
`endif
            end
            S_RADDR: begin
                if (frame_err) cmd_d = S_CMD;
                else if (rx_valid) begin
                    address_d = rx_shift_q;
                    cmd_d     = S_READ;
                end
            end
            S_READ: begin
                r_en  = 1'b1;
                cmd_d = S_RCAP;
            end
            S_RCAP: begin
                resp_d = din;
                cmd_d  = S_TXWAIT;
            end
            S_TXWAIT: begin
                if (!tx_active_q) begin
                    tx_start = 1'b1;
                    cmd_d    = S_CMD;
                end
            end
            default: cmd_d = S_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q       <= '0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_tcnt_q   <= 4'd0;
            rx_bcnt_q   <= 3'd0;
            rx_shift_q  <= 8'd0;
            tx_q        <= 1'b1;
            tx_active_q <= 1'b0;
            tx_tcnt_q   <= 4'd0;
            tx_bcnt_q   <= 4'd0;
            tx_frame_q  <= 10'h3FF;
            cmd_q       <= S_CMD;
            address_q   <= 8'd0;
            dout_q      <= 8'd0;
            resp_q      <= 8'd0;
        end else begin
            pre_q       <= pre_d;
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_state_q  <= rx_state_d;
            rx_tcnt_q   <= rx_tcnt_d;
            rx_bcnt_q   <= rx_bcnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_q        <= tx_d;
            tx_active_q <= tx_active_d;
            tx_tcnt_q   <= tx_tcnt_d;
            tx_bcnt_q   <= tx_bcnt_d;
            tx_frame_q  <= tx_frame_d;
            cmd_q       <= cmd_d;
            address_q   <= address_d;
            dout_q      <= dout_d;
            resp_q      <= resp_d;
        end
    end

endmodule
`default_nettype wire
